// File: rtl/axi_w_order_arbiter.sv
// Per-slave AW round-robin arbiter with in-order W steering from a grant FIFO.
// Define AXI_W_ORDER_BYPASS_EN to steer W from aw_sel while the FIFO is empty.
module axi_w_order_arbiter #(
    parameter int MST_NUM    = 3,
    parameter int SEL_W      = $clog2(MST_NUM),
    parameter int OSTD_DEPTH = 4,
    parameter int CNT_W      = $clog2(OSTD_DEPTH) + 1
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [MST_NUM-1:0] m_awvalid,
    output logic [MST_NUM-1:0] m_awready,
    output logic               s_awvalid,
    input  logic               s_awready,
    output logic [SEL_W-1:0]   aw_sel,
    input  logic [MST_NUM-1:0] m_wvalid,
    input  logic [MST_NUM-1:0] m_wlast,
    output logic [MST_NUM-1:0] m_wready,
    output logic               s_wvalid,
    output logic               s_wlast,
    input  logic               s_wready,
    output logic [SEL_W-1:0]   w_sel,
    output logic [CNT_W-1:0]   ostd_cnt
);

    localparam int PTR_W = $clog2(OSTD_DEPTH);

    typedef enum logic {
        IDLE,
        HOLD
    } aw_state_e;

    aw_state_e        state_q, state_d;
    logic [SEL_W-1:0] rr_ptr_q;
    logic [SEL_W-1:0] hold_sel_q, hold_sel_d;
    logic [SEL_W-1:0] last_sel_q;
    logic [SEL_W-1:0] pick;
    logic             any_req;
    int               idx;

    logic [SEL_W-1:0] fifo_q [OSTD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SEL_W-1:0] head;

    logic full, empty;
    logic aw_hs, bypass, w_active, w_done;
    logic push, pop;

    assign full     = (cnt_q == CNT_W'(OSTD_DEPTH));
    assign empty    = (cnt_q == '0);
    assign head     = fifo_q[rd_ptr_q];
    assign ostd_cnt = cnt_q;

    // Scan downwards so the requester closest to rr_ptr wins.
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = MST_NUM - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % MST_NUM;
            if (m_awvalid[idx]) begin
                pick    = SEL_W'(idx);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_sel_d = hold_sel_q;
        aw_sel     = '0;
        s_awvalid  = 1'b0;
        if (aresetn) begin
            unique case (state_q)
                IDLE: begin
                    aw_sel    = pick;
                    s_awvalid = any_req && !full;
                    if (any_req && !full && !s_awready) begin
                        state_d    = HOLD;
                        hold_sel_d = pick;
                    end
                end
                HOLD: begin
                    aw_sel    = hold_sel_q;
                    s_awvalid = m_awvalid[hold_sel_q];
                    if (s_awvalid && s_awready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign aw_hs = s_awvalid && s_awready;

    always_comb begin
        m_awready = '0;
        for (int i = 0; i < MST_NUM; i++) begin
            m_awready[i] = aw_hs && (aw_sel == SEL_W'(i));
        end
    end

`ifdef AXI_W_ORDER_BYPASS_EN
    assign bypass = empty && aw_hs;
`else
    assign bypass = 1'b0;
`endif

    assign w_active = !empty || bypass;

    always_comb begin
        w_sel = last_sel_q;
        if (!empty) begin
            w_sel = head;
        end else if (bypass) begin
            w_sel = aw_sel;
        end
    end

    assign s_wvalid = w_active && m_wvalid[w_sel];
    assign s_wlast  = w_active && m_wlast[w_sel];

    always_comb begin
        m_wready = '0;
        for (int i = 0; i < MST_NUM; i++) begin
            m_wready[i] = w_active && s_wready && (w_sel == SEL_W'(i));
        end
    end

    assign w_done = s_wvalid && s_wready && s_wlast;
    assign pop    = w_done && !empty;
    // A bypassed burst that completes in its AW cycle never needs a slot.
    assign push   = aw_hs && !full && !(bypass && w_done);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            hold_sel_q <= '0;
            last_sel_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < OSTD_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            hold_sel_q <= hold_sel_d;
            if (aw_hs) begin
                rr_ptr_q <= (aw_sel == SEL_W'(MST_NUM - 1)) ? '0 : aw_sel + 1'b1;
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= aw_sel;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (w_done) begin
                last_sel_q <= w_sel;
            end
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_axi_w_order_arbiter.sv
// Scoreboard bench for axi_w_order_arbiter: expected AW grants and W beats
// are queued by the stimulus and consumed by a negedge handshake monitor.
module tb_axi_w_order_arbiter;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic [2:0] m_awvalid, m_awready;
    logic       s_awvalid, s_awready;
    logic [1:0] aw_sel;
    logic [2:0] m_wvalid, m_wlast, m_wready;
    logic       s_wvalid, s_wlast, s_wready;
    logic [1:0] w_sel;
    logic [2:0] ostd_cnt;

    int errors = 0;
    int checks = 0;

    logic [1:0] exp_aw [$];
    logic [2:0] exp_w  [$];

    axi_w_order_arbiter dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .aw_sel    (aw_sel),
        .m_wvalid  (m_wvalid),
        .m_wlast   (m_wlast),
        .m_wready  (m_wready),
        .s_wvalid  (s_wvalid),
        .s_wlast   (s_wlast),
        .s_wready  (s_wready),
        .w_sel     (w_sel),
        .ostd_cnt  (ostd_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn   = 1'b0;
        m_awvalid = '0;
        s_awready = 1'b0;
        m_wvalid  = '0;
        m_wlast   = '0;
        s_wready  = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    // Monitor: every handshake must match the head of its expectation queue.
    always @(negedge aclk) begin
        if (aresetn === 1'b1) begin
            if (s_awvalid && s_awready) begin
                if (exp_aw.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL aw_unexpected: got sel %0d expected none", aw_sel);
                end else begin
                    chk("aw_sel", aw_sel, exp_aw.pop_front());
                end
                chk("m_awready", m_awready, 3'b001 << aw_sel);
            end else begin
                chk("m_awready_idle", m_awready, 0);
            end
            if (s_wvalid && s_wready) begin
                if (exp_w.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL w_unexpected: got sel %0d expected none", w_sel);
                end else begin
                    logic [2:0] e;
                    e = exp_w.pop_front();
                    chk("w_sel", w_sel, e[1:0]);
                    chk("w_last", s_wlast, e[2]);
                end
                chk("m_wready", m_wready, 3'b001 << w_sel);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        aresetn   = 1'b0;
        m_awvalid = 3'b111;
        s_awready = 1'b0;
        m_wvalid  = 3'b111;
        m_wlast   = 3'b111;
        s_wready  = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_s_awvalid", s_awvalid, 0);
        chk("rst_m_awready", m_awready, 0);
        chk("rst_aw_sel", aw_sel, 0);
        chk("rst_s_wvalid", s_wvalid, 0);
        chk("rst_s_wlast", s_wlast, 0);
        chk("rst_m_wready", m_wready, 0);
        chk("rst_w_sel", w_sel, 0);
        chk("rst_ostd_cnt", ostd_cnt, 0);
        aresetn  = 1'b1;
        m_wvalid = '0;
        #1;
        chk("rel_s_awvalid", s_awvalid, 1);
        chk("rel_aw_sel", aw_sel, 0);

        // Round-robin fill until the grant FIFO is full.
        do_reset();
        m_awvalid = 3'b111;
        s_awready = 1'b1;
        exp_aw.push_back(2'd0);
        exp_aw.push_back(2'd1);
        exp_aw.push_back(2'd2);
        exp_aw.push_back(2'd0);
        repeat (4) tick();
        chk("rr_full_awvalid", s_awvalid, 0);
        chk("rr_full_cnt", ostd_cnt, 4);
        tick();
        chk("rr_stall_cnt", ostd_cnt, 4);

        // WLAST pop while full: push is blocked that cycle.
        m_wvalid = 3'b001;
        m_wlast  = 3'b001;
        s_wready = 1'b1;
        #1;
        chk("full_pop_awvalid", s_awvalid, 0);
        chk("full_pop_wvalid", s_wvalid, 1);
        exp_w.push_back({1'b1, 2'd0});
        tick();
        m_wvalid = '0;
        #1;
        chk("full_pop_cnt", ostd_cnt, 3);
        chk("full_next_awvalid", s_awvalid, 1);
        exp_aw.push_back(2'd1);
        tick();
        chk("full_refill_cnt", ostd_cnt, 4);

        // Drain the FIFO in order 1,2,0,1.
        m_awvalid = '0;
        s_awready = 1'b0;
        m_wvalid  = 3'b111;
        m_wlast   = 3'b111;
        exp_w.push_back({1'b1, 2'd1});
        exp_w.push_back({1'b1, 2'd2});
        exp_w.push_back({1'b1, 2'd0});
        exp_w.push_back({1'b1, 2'd1});
        repeat (4) tick();
        chk("drain_cnt", ostd_cnt, 0);
        chk("empty_s_wvalid", s_wvalid, 0);
        chk("empty_m_wready", m_wready, 0);
        chk("empty_w_sel", w_sel, 1);
        m_wvalid = '0;

        // Hold stability: master 1 stays granted while master 0 joins.
        m_awvalid = 3'b010;
        s_awready = 1'b0;
        tick();
        m_awvalid = 3'b011;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("hold_aw_sel", aw_sel, 1);
            chk("hold_s_awvalid", s_awvalid, 1);
            tick();
        end
        exp_aw.push_back(2'd1);
        s_awready = 1'b1;
        tick();
        m_awvalid = 3'b111;
        exp_aw.push_back(2'd2);
        tick();
        m_awvalid = 3'b011;
        exp_aw.push_back(2'd0);
        tick();
        m_awvalid = '0;
        s_awready = 1'b0;
        #1;
        chk("hold_cnt", ostd_cnt, 3);
        m_wvalid = 3'b111;
        m_wlast  = 3'b111;
        s_wready = 1'b1;
        exp_w.push_back({1'b1, 2'd1});
        exp_w.push_back({1'b1, 2'd2});
        exp_w.push_back({1'b1, 2'd0});
        repeat (3) tick();
        m_wvalid = '0;
        #1;
        chk("hold_drain_cnt", ostd_cnt, 0);

        // Ordering: 4-beat burst from master 2, then 1 beat from master 0.
        m_awvalid = 3'b100;
        s_awready = 1'b1;
        exp_aw.push_back(2'd2);
        tick();
        m_awvalid = 3'b001;
        exp_aw.push_back(2'd0);
        tick();
        m_awvalid = '0;
        s_awready = 1'b0;
        m_wvalid  = 3'b101;
        m_wlast   = 3'b001;
        s_wready  = 1'b1;
        for (int b = 0; b < 3; b++) begin
            exp_w.push_back({1'b0, 2'd2});
            #1;
            chk("order_m_wready", m_wready, 3'b100);
            tick();
        end
        m_wlast = 3'b101;
        exp_w.push_back({1'b1, 2'd2});
        tick();
        exp_w.push_back({1'b1, 2'd0});
        tick();
        m_wvalid = '0;
        #1;
        chk("order_cnt", ostd_cnt, 0);

        // Single-beat burst presented in the same cycle as its AW.
        m_awvalid = 3'b010;
        s_awready = 1'b1;
        m_wvalid  = 3'b010;
        m_wlast   = 3'b010;
        s_wready  = 1'b1;
        exp_aw.push_back(2'd1);
        #1;
`ifdef AXI_W_ORDER_BYPASS_EN
        chk("byp_s_wvalid", s_wvalid, 1);
        chk("byp_w_sel", w_sel, 1);
        exp_w.push_back({1'b1, 2'd1});
        tick();
        m_awvalid = '0;
        s_awready = 1'b0;
        m_wvalid  = '0;
        #1;
        chk("byp_cnt", ostd_cnt, 0);
`else
        chk("nobyp_s_wvalid", s_wvalid, 0);
        chk("nobyp_m_wready", m_wready, 0);
        tick();
        m_awvalid = '0;
        s_awready = 1'b0;
        #1;
        chk("nobyp_cnt_pulse", ostd_cnt, 1);
        chk("nobyp_late_wvalid", s_wvalid, 1);
        chk("nobyp_late_w_sel", w_sel, 1);
        exp_w.push_back({1'b1, 2'd1});
        tick();
        m_wvalid = '0;
        #1;
        chk("nobyp_cnt", ostd_cnt, 0);
`endif

        // Asynchronous reset with a grant outstanding.
        m_awvalid = 3'b001;
        s_awready = 1'b1;
        s_wready  = 1'b0;
        exp_aw.push_back(2'd0);
        tick();
        m_awvalid = '0;
        s_awready = 1'b0;
        m_wvalid  = 3'b001;
        m_wlast   = 3'b001;
        #1;
        chk("pre_rst_cnt", ostd_cnt, 1);
        chk("pre_rst_wvalid", s_wvalid, 1);
        aresetn = 1'b0;
        #1;
        chk("async_rst_cnt", ostd_cnt, 0);
        chk("async_rst_wvalid", s_wvalid, 0);

        chk("aw_queue_left", exp_aw.size(), 0);
        chk("w_queue_left", exp_w.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
